// File: rtl/snake_pkg.sv
// Shared playfield geometry, bus widths and fruit generator state encoding
// for the snake game blocks.
package snake_pkg;

  localparam int unsigned COORD_W          = 7;
  localparam int unsigned SNAKE_LENGTH_BIT = 6;
  localparam int unsigned GRID_W           = 80;
  localparam int unsigned GRID_H           = 60;
  localparam int unsigned PLAY_Y_MIN       = 4;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    GEN_IDLE,
    GEN_SAMPLE,
    GEN_SCAN,
    GEN_COMMIT
  } gen_state_e;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the fruit
// candidate source; reseeded only by the full reset.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock_25,
  input  logic        reset,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/fruit_generator.sv
// Picks a new fruit cell after each fruit_eaten pulse: samples LFSR candidates
// and rejects those off-field, on the head, or on any body segment.
module fruit_generator #(
  parameter int unsigned SNAKE_LENGTH_BIT = snake_pkg::SNAKE_LENGTH_BIT,
  parameter int unsigned GRID_W           = snake_pkg::GRID_W,
  parameter int unsigned GRID_H           = snake_pkg::GRID_H,
  parameter int unsigned PLAY_Y_MIN       = snake_pkg::PLAY_Y_MIN,
  parameter int unsigned INIT_FRUIT_X     = 40,
  parameter int unsigned INIT_FRUIT_Y     = 30,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic                              clock_25,
  input  logic                              reset,
  input  logic                              sync_reset,
  input  logic                              fruit_eaten,
  input  logic [snake_pkg::COORD_W-1:0]     snake_head_x,
  input  logic [snake_pkg::COORD_W-1:0]     snake_head_y,
  input  logic [SNAKE_LENGTH_BIT-1:0]       snake_length,
  output logic [SNAKE_LENGTH_BIT-1:0]       body_index,
  input  logic [snake_pkg::COORD_W-1:0]     snake_body_x,
  input  logic [snake_pkg::COORD_W-1:0]     snake_body_y,
  output logic [snake_pkg::COORD_W-1:0]     fruit_x,
  output logic [snake_pkg::COORD_W-1:0]     fruit_y,
  output logic                              fruit_valid,
  output logic                              busy,
  output logic [3:0]                        retry_count
);

  import snake_pkg::*;

  localparam coord_t X_LIM   = coord_t'(GRID_W);
  localparam coord_t Y_LIM   = coord_t'(GRID_H);
  localparam coord_t Y_MIN   = coord_t'(PLAY_Y_MIN);
  localparam coord_t X_RESET = coord_t'(INIT_FRUIT_X);
  localparam coord_t Y_RESET = coord_t'(INIT_FRUIT_Y);

  gen_state_e state_q, state_d;

  logic [15:0]                 lfsr;
  coord_t                      samp_x, samp_y;
  logic                        samp_ok;
  logic [SNAKE_LENGTH_BIT-1:0] len_m1;
  logic                        issue;
  logic                        body_hit;
  logic                        scan_last;
  logic                        unused_lfsr_bits;

  coord_t                      cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  coord_t                      fruit_x_q, fruit_x_d, fruit_y_q, fruit_y_d;
  logic [SNAKE_LENGTH_BIT-1:0] body_index_q, body_index_d;
  logic [3:0]                  retry_q, retry_d;
  logic                        cmp_valid_q, cmp_valid_d;
  logic                        issued_last_q, issued_last_d;

  lfsr16 #(
    .SEED     (LFSR_SEED)
  ) u_lfsr (
    .clock_25 (clock_25),
    .reset    (reset),
    .state_o  (lfsr)
  );

  assign samp_x           = lfsr[6:0];
  assign samp_y           = lfsr[14:8];
  assign unused_lfsr_bits = lfsr[15] ^ lfsr[7];

  assign samp_ok = (samp_x < X_LIM) && (samp_y >= Y_MIN) && (samp_y < Y_LIM) &&
                   !((samp_x == snake_head_x) && (samp_y == snake_head_y));

  // Reads are issued until index length-1 has gone out; the compare of each
  // read lands one cycle later, so the last compare is flagged by issued_last_q.
  assign len_m1    = snake_length - SNAKE_LENGTH_BIT'(1);
  assign issue     = (state_q == GEN_SCAN) && !issued_last_q;
  assign body_hit  = cmp_valid_q && (snake_body_x == cand_x_q) && (snake_body_y == cand_y_q);
  assign scan_last = cmp_valid_q && issued_last_q;

  always_ff @(posedge clock_25) begin
    if (reset || sync_reset) begin
      state_q <= GEN_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GEN_IDLE: begin
        if (fruit_eaten) state_d = GEN_SAMPLE;
      end
      GEN_SAMPLE: begin
        if (samp_ok) state_d = (snake_length != '0) ? GEN_SCAN : GEN_COMMIT;
      end
      GEN_SCAN: begin
        if (body_hit) begin
          state_d = GEN_SAMPLE;
        end else if (scan_last) begin
          state_d = GEN_COMMIT;
        end
      end
      GEN_COMMIT: begin
        state_d = GEN_IDLE;
      end
      default: state_d = GEN_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != GEN_IDLE);
    fruit_valid = (state_q == GEN_IDLE);
    fruit_x     = fruit_x_q;
    fruit_y     = fruit_y_q;
    body_index  = body_index_q;
    retry_count = retry_q;
  end

  always_comb begin
    cand_x_d      = cand_x_q;
    cand_y_d      = cand_y_q;
    fruit_x_d     = fruit_x_q;
    fruit_y_d     = fruit_y_q;
    body_index_d  = body_index_q;
    retry_d       = retry_q;
    cmp_valid_d   = issue;
    issued_last_d = (state_q == GEN_SCAN) && (issued_last_q || (body_index_q == len_m1));

    unique case (state_q)
      GEN_IDLE: begin
        if (fruit_eaten) retry_d = '0;
      end
      GEN_SAMPLE: begin
        cand_x_d = samp_x;
        cand_y_d = samp_y;
        if (samp_ok) begin
          body_index_d = '0;
        end else if (retry_q != 4'hF) begin
          retry_d = retry_q + 4'd1;
        end
      end
      GEN_SCAN: begin
        if (body_hit && (retry_q != 4'hF)) retry_d = retry_q + 4'd1;
        if (issue && (body_index_q != len_m1)) body_index_d = body_index_q + SNAKE_LENGTH_BIT'(1);
      end
      GEN_COMMIT: begin
        fruit_x_d = cand_x_q;
        fruit_y_d = cand_y_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_25) begin
    if (reset || sync_reset) begin
      cand_x_q      <= '0;
      cand_y_q      <= '0;
      fruit_x_q     <= X_RESET;
      fruit_y_q     <= Y_RESET;
      body_index_q  <= '0;
      retry_q       <= '0;
      cmp_valid_q   <= 1'b0;
      issued_last_q <= 1'b0;
    end else begin
      cand_x_q      <= cand_x_d;
      cand_y_q      <= cand_y_d;
      fruit_x_q     <= fruit_x_d;
      fruit_y_q     <= fruit_y_d;
      body_index_q  <= body_index_d;
      retry_q       <= retry_d;
      cmp_valid_q   <= cmp_valid_d;
      issued_last_q <= issued_last_d;
    end
  end

endmodule

// File: tb/tb_fruit_generator.sv
// Self-checking bench for fruit_generator: a transaction-level model predicts
// each generation's fruit, retry count and commit cycle from the LFSR sequence.
module tb_fruit_generator;

  logic       clock_25 = 1'b0;
  logic       reset;
  logic       sync_reset;
  logic       fruit_eaten;
  logic [6:0] snake_head_x, snake_head_y;
  logic [5:0] snake_length;
  logic [5:0] body_index;
  logic [6:0] snake_body_x, snake_body_y;
  logic [6:0] fruit_x, fruit_y;
  logic       fruit_valid;
  logic       busy;
  logic [3:0] retry_count;

  int checks = 0;
  int errors = 0;
  int mLfsr  = 0;
  int headX, headY, bodyLen;
  int bodyX [64];
  int bodyY [64];

  fruit_generator dut (
    .clock_25     (clock_25),
    .reset        (reset),
    .sync_reset   (sync_reset),
    .fruit_eaten  (fruit_eaten),
    .snake_head_x (snake_head_x),
    .snake_head_y (snake_head_y),
    .snake_length (snake_length),
    .body_index   (body_index),
    .snake_body_x (snake_body_x),
    .snake_body_y (snake_body_y),
    .fruit_x      (fruit_x),
    .fruit_y      (fruit_y),
    .fruit_valid  (fruit_valid),
    .busy         (busy),
    .retry_count  (retry_count)
  );

  always #20 clock_25 = ~clock_25;

  assign snake_head_x = 7'(headX);
  assign snake_head_y = 7'(headY);
  assign snake_length = 6'(bodyLen);

  // Segment memory of the game FSM: data appears one cycle after the index.
  always @(posedge clock_25) begin
    snake_body_x <= 7'(bodyX[body_index]);
    snake_body_y <= 7'(bodyY[body_index]);
  end

  function automatic int nextLfsr(input int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 32'hFFFF;
  endfunction

  always @(posedge clock_25) begin
    if (reset) mLfsr <= 32'hACE1;
    else       mLfsr <= nextLfsr(mLfsr);
  end

  function automatic bit inField(input int x, input int y);
    return (x < 80) && (y >= 4) && (y < 60);
  endfunction

  function automatic bit candOk(input int v);
    int x, y;
    x = v & 127;
    y = (v >> 8) & 127;
    return inField(x, y) && !((x == headX) && (y == headY));
  endfunction

  // First LFSR value from v onward that passes the field (and optionally head) test.
  function automatic int firstUsable(input int v, input bit useHead);
    int w;
    w = v;
    for (int i = 0; i < 400; i++) begin
      if (useHead ? candOk(w) : inField(w & 127, (w >> 8) & 127)) return w;
      w = nextLfsr(w);
    end
    return w;
  endfunction

  // Walks the candidate sequence starting at the cycle-1 LFSR value and
  // returns the cell committed, the retry tally and the COMMIT cycle.
  task automatic predict(input int startV, output int ex, output int ey,
                         output int er, output int ec);
    int v, t, m, x, y;
    bit done;
    v = startV; t = 1; er = 0; done = 0; ex = 0; ey = 0; ec = 2;
    for (int guard = 0; guard < 5000 && !done; guard++) begin
      x = v & 127;
      y = (v >> 8) & 127;
      if (!candOk(v)) begin
        er = (er < 15) ? er + 1 : 15;
        v = nextLfsr(v);
        t = t + 1;
      end else begin
        m = -1;
        for (int i = 0; i < bodyLen; i++) begin
          if (m < 0 && bodyX[i] == x && bodyY[i] == y) m = i;
        end
        if (m >= 0) begin
          er = (er < 15) ? er + 1 : 15;
          for (int s = 0; s < m + 3; s++) v = nextLfsr(v);
          t = t + m + 3;
        end else begin
          ex = x;
          ey = y;
          ec = (bodyLen == 0) ? t + 1 : t + bodyLen + 2;
          done = 1;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one fruit_eaten at the current negedge and follows the generation
  // cycle by cycle until one cycle past its predicted commit.
  task automatic applyStimulus(input bit doubleEat);
    int ex, ey, er, ec;
    bit onBody;
    predict(nextLfsr(mLfsr), ex, ey, er, ec);
    fruit_eaten = 1'b1;
    @(negedge clock_25);
    for (int k = 1; k <= ec + 1; k++) begin
      checkOutput("busy", 32'(busy), 32'(k <= ec));
      checkOutput("fruit_valid", 32'(fruit_valid), 32'(k > ec));
      if (k == 1) checkOutput("retry_cleared", 32'(retry_count), 32'd0);
      fruit_eaten = doubleEat && (k == 2);
      if (k == ec + 1) begin
        checkOutput("fruit_x", 32'(fruit_x), 32'(ex));
        checkOutput("fruit_y", 32'(fruit_y), 32'(ey));
        checkOutput("retry_count", 32'(retry_count), 32'(er));
        onBody = (32'(fruit_x) == 32'(headX)) && (32'(fruit_y) == 32'(headY));
        for (int i = 0; i < bodyLen; i++) begin
          if (32'(fruit_x) == 32'(bodyX[i]) && 32'(fruit_y) == 32'(bodyY[i])) onBody = 1'b1;
        end
        checkOutput("fruit_on_snake", 32'(onBody), 32'd0);
        checkOutput("fruit_in_field", 32'(inField(32'(fruit_x), 32'(fruit_y))), 32'd1);
      end else begin
        @(negedge clock_25);
      end
    end
    if (doubleEat) begin
      repeat (3) begin
        @(negedge clock_25);
        checkOutput("no_second_commit", 32'(busy), 32'd0);
      end
    end
  endtask

  task automatic randomBody(input int len);
    bodyLen = len;
    for (int i = 0; i < 64; i++) begin
      bodyX[i] = $urandom_range(0, 79);
      bodyY[i] = $urandom_range(4, 59);
    end
  endtask

  task automatic waitForGoodCandidate();
    for (int i = 0; i < 500 && !candOk(nextLfsr(mLfsr)); i++) @(negedge clock_25);
  endtask

  initial begin
    int w, idx;
    reset = 1'b1; sync_reset = 1'b0; fruit_eaten = 1'b0;
    headX = 0; headY = 0;
    randomBody(0);

    repeat (3) @(negedge clock_25);
    checkOutput("reset_fruit_x", 32'(fruit_x), 32'd40);
    checkOutput("reset_fruit_y", 32'(fruit_y), 32'd30);
    checkOutput("reset_valid", 32'(fruit_valid), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_index", 32'(body_index), 32'd0);
    checkOutput("reset_retry", 32'(retry_count), 32'd0);
    reset = 1'b0;
    @(negedge clock_25);

    $display("[TB] empty snake, first candidate usable");
    waitForGoodCandidate();
    applyStimulus(1'b0);

    $display("[TB] candidate collides with body index 3");
    headX = 70; headY = 50;
    randomBody(5);
    w = firstUsable(nextLfsr(mLfsr), 1'b1);
    bodyX[3] = w & 127;
    bodyY[3] = (w >> 8) & 127;
    applyStimulus(1'b0);
    checkOutput("avoided_blocked_cell",
                32'((32'(fruit_x) == 32'(bodyX[3])) && (32'(fruit_y) == 32'(bodyY[3]))), 32'd0);

    $display("[TB] sync_reset during scan with coincident fruit_eaten");
    randomBody(30);
    waitForGoodCandidate();
    fruit_eaten = 1'b1;
    @(negedge clock_25);
    fruit_eaten = 1'b0;
    repeat (3) @(negedge clock_25);
    sync_reset = 1'b1;
    fruit_eaten = 1'b1;
    @(negedge clock_25);
    sync_reset = 1'b0;
    fruit_eaten = 1'b0;
    checkOutput("sync_fruit_x", 32'(fruit_x), 32'd40);
    checkOutput("sync_fruit_y", 32'(fruit_y), 32'd30);
    checkOutput("sync_valid", 32'(fruit_valid), 32'd1);
    checkOutput("sync_busy", 32'(busy), 32'd0);
    checkOutput("sync_retry", 32'(retry_count), 32'd0);
    checkOutput("sync_index", 32'(body_index), 32'd0);
    @(negedge clock_25);
    checkOutput("sync_wins_over_eat", 32'(busy), 32'd0);

    $display("[TB] second fruit_eaten while busy");
    randomBody(10);
    applyStimulus(1'b1);

    $display("[TB] random soak");
    for (int n = 0; n < 700; n++) begin
      headX = $urandom_range(0, 79);
      headY = $urandom_range(4, 59);
      randomBody($urandom_range(0, 63));
      repeat ($urandom_range(0, 3)) @(negedge clock_25);
      if ($urandom_range(0, 7) == 0) begin
        w = firstUsable(nextLfsr(mLfsr), 1'b0);
        headX = w & 127;
        headY = (w >> 8) & 127;
      end else if (bodyLen > 0 && $urandom_range(0, 3) == 0) begin
        w = firstUsable(nextLfsr(mLfsr), 1'b1);
        idx = $urandom_range(0, bodyLen - 1);
        bodyX[idx] = w & 127;
        bodyY[idx] = (w >> 8) & 127;
      end
      applyStimulus($urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fruit_generator.md
# fruit_generator

Places a new fruit on the playfield whenever the snake game FSM reports a fruit eaten. It produces the `fruit_x`/`fruit_y` coordinates that the game FSM and renderer consume. Candidates come from a free-running LFSR and are checked against the head and every body segment; occupied or off-field candidates are resampled. The body is read through the game FSM's existing segment port (`body_index` → `snake_body_x/y`, 1-cycle read latency).

## Interface
Parameters:
- `SNAKE_LENGTH_BIT`, 6: width of length/index buses
- `GRID_W`, 80: playfield columns, valid x = 0..GRID_W-1
- `GRID_H`, 60: playfield rows (exclusive upper y bound)
- `PLAY_Y_MIN`, 4: first playable row; rows above are the score/time HUD
- `INIT_FRUIT_X`, 40: fruit x after reset/sync_reset
- `INIT_FRUIT_Y`, 30: fruit y after reset/sync_reset
- `LFSR_SEED`, 16'hACE1: LFSR value after `reset`; must be non-zero

Ports:
- `clock_25` in 1: system clock, 25 MHz
- `reset` in 1: synchronous, active-high, full reset
- `sync_reset` in 1: game restart; restores the initial fruit but not the LFSR
- `fruit_eaten` in 1: 1-cycle pulse requesting a new fruit
- `snake_head_x`, `snake_head_y` in 7: current head cell
- `snake_length` in SNAKE_LENGTH_BIT: number of body segments stored at indices 0..snake_length-1
- `body_index` out SNAKE_LENGTH_BIT: segment read address
- `snake_body_x`, `snake_body_y` in 7: segment data, valid 1 cycle after `body_index`
- `fruit_x`, `fruit_y` out 7: committed fruit cell
- `fruit_valid` out 1: high when `fruit_x/y` are committed and usable
- `busy` out 1: high while generating
- `retry_count` out 4: rejected candidates in the current/last generation, saturates at 15

## Operation
- LFSR: 16 bits, Fibonacci taps 16,14,13,11, shifts every cycle in every state. `reset` loads LFSR_SEED. `sync_reset` does not affect it.
- Candidate: x = lfsr[6:0], y = lfsr[14:8].
  - In-range requires x < GRID_W and PLAY_Y_MIN ≤ y < GRID_H.
  - An out-of-range candidate is a rejection.
- States:
  - IDLE: `busy` = 0, `fruit_valid` = 1. On `fruit_eaten`: clear `retry_count`, go to SAMPLE, drop `fruit_valid`.
  - SAMPLE: latch the candidate into `cand_x/y`.
    - Rejection if out of range, or if it equals `snake_head_x/y` → retry_count+1 (saturating), stay in SAMPLE.
    - Otherwise: `body_index` ← 0. Go to SCAN if snake_length > 0, else COMMIT.
  - SCAN: increment `body_index` each cycle up to snake_length-1. Compare returned data (1-cycle delayed valid flag) against the candidate.
    - Any match → retry_count+1, return to SAMPLE. Remaining reads are abandoned.
    - Compare of index snake_length-1 with no match → COMMIT.
  - COMMIT: `fruit_x/y` ← `cand_x/y`, `fruit_valid` ← 1, go to IDLE.
- `fruit_eaten` outside IDLE is ignored.
- `sync_reset` in any state forces IDLE with `fruit_x/y` = INIT_FRUIT_X/Y, `fruit_valid` = 1, `busy` = 0, `body_index` = 0, `retry_count` = 0. It wins over a coincident `fruit_eaten`.
- `reset` does the same, and also reseeds the LFSR.
- No retry cap. Termination is probabilistic; ≤63 segments out of 4480 cells.

## Timing
- Reset values: fruit_x = 40, fruit_y = 30, fruit_valid = 1, busy = 0, body_index = 0, retry_count = 0.
- `fruit_eaten` sampled at edge 0 → SAMPLE at cycle 1.
- No rejection, length L > 0:
  - SCAN issues indices at cycles 2..L+1.
  - The last compare is at cycle L+2.
  - COMMIT at cycle L+3; `fruit_x/y` and `fruit_valid` update at the end of cycle L+3.
- L = 0: commit at the end of cycle 2.
- Each rejection adds 1 cycle (SAMPLE-stage rejection) or 1 + (cycles spent in SCAN).
- `busy` is high from cycle 1 until the COMMIT edge.
- `fruit_valid` = ~busy at all times.
- Snake head/body/length must be stable while `busy`; the game tick period far exceeds the worst-case scan.

## Structure
- Shared package `snake_pkg`:
  - GRID_W, GRID_H, PLAY_Y_MIN
  - coordinate width (7)
  - SNAKE_LENGTH_BIT
  - generator state encoding (IDLE, SAMPLE, SCAN, COMMIT)
- Sub-module `lfsr16`: clock_25, reset, seed parameter, 16-bit state output.
- The FSM, compare pipeline and fruit registers stay in `fruit_generator`.

## Test plan
- Reset, then force the LFSR output to in-range (10,20), L = 0, pulse `fruit_eaten` → fruit = (10,20) at the end of cycle 2, retry_count = 0, busy high for exactly cycles 1–2.
- Candidate (10,20) equals body index 3 of L = 5, next candidate free → retry_count = 1, committed fruit ≠ (10,20), `body_index` restarts at 0.
- Candidate x = 100 or y = 2 → rejected in SAMPLE, retry_count increments, `body_index` never driven for it.
- `sync_reset` asserted mid-SCAN together with `fruit_eaten` → next cycle: IDLE, fruit = (40,30), fruit_valid = 1, busy = 0.
- Second `fruit_eaten` while busy → ignored, exactly one commit.
- Random soak of 10k requests with a random snake up to 63 segments → committed fruit is never on the head/body and always in range; `fruit_valid` == ~busy every cycle.
